bsg_nary_logic_pipe: RTL and testbench

//   Parametrised, pipelined successor to the fixed 3-input/4-bit hardened NOR cell.

---
 rtl/bsg_nary_logic_pipe.sv | 106 ++++++++++
 tb/tb_bsg_nary_logic_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_nary_logic_pipe.sv
// Bit-wise n-ary NOR/OR/NAND/XOR reduction of els_p operands, followed by a
// stages_p-deep bubble-collapsing valid/ready pipeline with a valid/yumi output.
module bsg_nary_logic_pipe #(
   parameter int width_p  = 4,
   parameter int els_p    = 3,
   parameter int stages_p = 2
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic                              v_i,
   output logic                              ready_o,
   input  logic [els_p*width_p-1:0]          data_i,
   input  logic [1:0]                        mode_i,
   output logic                              v_o,
   output logic [width_p-1:0]                data_o,
   input  logic                              yumi_i,
   output logic [$clog2(stages_p+1)-1:0]     count_o
);

   localparam int CW = $clog2(stages_p+1);

   typedef enum logic [1:0] {
      MODE_NOR  = 2'd0,
      MODE_OR   = 2'd1,
      MODE_NAND = 2'd2,
      MODE_XOR  = 2'd3
   } mode_e;

   mode_e                w_mode;
   logic [width_p-1:0]   w_or, w_and, w_xor, w_red;
   logic [stages_p-1:0]  w_load;
   logic                 w_enq, w_deq;

   logic [stages_p-1:0]  r_v;
   logic [width_p-1:0]   r_d [stages_p];
   logic [CW-1:0]        r_cnt;

   assign w_mode = mode_e'(mode_i);

   always_comb begin
      w_or  = '0;
      w_and = '1;
      w_xor = '0;
      for (int unsigned k = 0; k < els_p; k++) begin
         w_or  = w_or  | data_i[k*width_p +: width_p];
         w_and = w_and & data_i[k*width_p +: width_p];
         w_xor = w_xor ^ data_i[k*width_p +: width_p];
      end
      w_red = '0;
      case (w_mode)
         MODE_NOR:  w_red = ~w_or;
         MODE_OR:   w_red = w_or;
         MODE_NAND: w_red = ~w_and;
         default:   w_red = w_xor;
      endcase
   end

   // Stage s may load when any stage at or after s is empty, or the output is taken;
   // this is the unrolled form of the per-stage chain and avoids a combinational loop.
   always_comb begin
      logic w_l;
      w_load = '0;
      for (int unsigned s = 0; s < stages_p; s++) begin
         w_l = yumi_i;
         for (int unsigned t = s; t < stages_p; t++) begin
            w_l = w_l | ~r_v[t];
         end
         w_load[s] = w_l;
      end
   end

   assign ready_o = w_load[0];
   assign w_enq   = v_i & w_load[0];
   assign w_deq   = yumi_i & r_v[stages_p-1];

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_v   <= '0;
         r_cnt <= '0;
         for (int unsigned s = 0; s < stages_p; s++) begin
            r_d[s] <= '0;
         end
      end else begin
         if (w_load[0]) begin
            r_v[0] <= v_i;
            r_d[0] <= w_red;
         end
         for (int unsigned s = 1; s < stages_p; s++) begin
            if (w_load[s]) begin
               r_v[s] <= r_v[s-1];
               r_d[s] <= r_d[s-1];
            end
         end
         r_cnt <= r_cnt + CW'(w_enq) - CW'(w_deq);
      end
   end

   assign v_o     = r_v[stages_p-1];
   assign data_o  = r_d[stages_p-1];
   assign count_o = r_cnt;

   a_no_yumi_when_empty : assert property (
      @(posedge clk_i) disable iff (reset_i) !(yumi_i && !r_v[stages_p-1])
   ) else $warning("yumi_i asserted while v_o=0");

endmodule

// File: tb/tb_bsg_nary_logic_pipe.sv
// Self-checking bench for bsg_nary_logic_pipe: directed table on the default
// configuration plus randomised valid/yumi traffic on several parameter sets.
module tb_bsg_nary_logic_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input bit ok, input string nm,
                      input longint unsigned act, input longint unsigned req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   // ---------------- default-configuration DUT ----------------
   logic        rst;
   logic        v_i, ready_o, v_o, yumi_i;
   logic        yumi_en, yumi_force;
   logic [11:0] data_i;
   logic [1:0]  mode_i;
   logic [3:0]  data_o, exp_in, e_main;
   logic [1:0]  count_o;
   logic [3:0]  exp_q[$];
   int          cnt_m;
   bit          go;

   assign yumi_i = yumi_force | (yumi_en & v_o);

   bsg_nary_logic_pipe #(.width_p(4), .els_p(3), .stages_p(2)) u_dut (
      .clk_i   (clk),
      .reset_i (rst),
      .v_i     (v_i),
      .ready_o (ready_o),
      .data_i  (data_i),
      .mode_i  (mode_i),
      .v_o     (v_o),
      .data_o  (data_o),
      .yumi_i  (yumi_i),
      .count_o (count_o)
   );

   // Scoreboard: push on input transfer, pop and compare on consumption.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         cnt_m = 0;
      end else begin
         chk(int'(count_o) == cnt_m, "count", count_o, cnt_m);
         chk(ready_o == ((cnt_m < 2) || yumi_i), "ready", ready_o, (cnt_m < 2) || yumi_i);
         if (yumi_i && v_o) begin
            chk(exp_q.size() != 0, "extra_output", data_o, 0);
            if (exp_q.size() != 0) begin
               e_main = exp_q.pop_front();
               chk(data_o == e_main, "data", data_o, e_main);
            end
            cnt_m--;
         end
         if (v_i && ready_o) begin
            exp_q.push_back(exp_in);
            cnt_m++;
         end
      end
   end

   typedef struct {
      logic [1:0]  mode;
      logic [11:0] data;
      logic [3:0]  expd;
   } vec_t;

   vec_t vecs [12];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] m, input logic [11:0] d, input logic [3:0] e);
      v_i    = 1'b1;
      mode_i = m;
      data_i = d;
      exp_in = e;
   endtask

   task automatic drain(input int bound, input string nm);
      for (int n = 0; n < bound && exp_q.size() != 0; n++) cyc();
      chk(exp_q.size() == 0, nm, exp_q.size(), 0);
   endtask

   // ---------------- randomised configurations ----------------
   function automatic int cfg_s(input int g);
      case (g) 0: return 1; 1: return 2; 2: return 3; default: return 4; endcase
   endfunction
   function automatic int cfg_e(input int g);
      case (g) 0: return 1; 1: return 3; 2: return 5; default: return 3; endcase
   endfunction
   function automatic int cfg_w(input int g);
      case (g) 0: return 1; 1: return 4; 2: return 17; default: return 4; endcase
   endfunction

   for (genvar g = 0; g < 4; g++) begin : gen_cfg
      localparam int S  = cfg_s(g);
      localparam int E  = cfg_e(g);
      localparam int W  = cfg_w(g);
      localparam int CW = $clog2(S+1);

      logic           gv, gready, gvo, gyen, gyumi, gdone;
      logic [E*W-1:0] gdata;
      logic [1:0]     gmode;
      logic [W-1:0]   gdo, gexp, ge;
      logic [CW-1:0]  gcnt;
      logic [W-1:0]   q[$];
      int             gcnt_m;

      assign gyumi = gyen & gvo;

      bsg_nary_logic_pipe #(.width_p(W), .els_p(E), .stages_p(S)) u_dut (
         .clk_i   (clk),
         .reset_i (rst),
         .v_i     (gv),
         .ready_o (gready),
         .data_i  (gdata),
         .mode_i  (gmode),
         .v_o     (gvo),
         .data_o  (gdo),
         .yumi_i  (gyumi),
         .count_o (gcnt)
      );

      // Reference: count ones per bit column.
      function automatic logic [W-1:0] ref_red(input logic [E*W-1:0] d, input logic [1:0] m);
         logic [W-1:0] r;
         int ones;
         r = '0;
         for (int j = 0; j < W; j++) begin
            ones = 0;
            for (int k = 0; k < E; k++) ones += int'(d[k*W+j]);
            case (m)
               2'd0:    r[j] = (ones == 0);
               2'd1:    r[j] = (ones != 0);
               2'd2:    r[j] = (ones != E);
               default: r[j] = ones[0];
            endcase
         end
         return r;
      endfunction

      always @(negedge clk) begin
         if (rst) begin
            q.delete();
            gcnt_m = 0;
         end else begin
            chk(int'(gcnt) == gcnt_m, $sformatf("cfg%0d_count", g), gcnt, gcnt_m);
            chk(gready == ((gcnt_m < S) || gyumi), $sformatf("cfg%0d_ready", g),
                gready, (gcnt_m < S) || gyumi);
            if (gyumi && gvo) begin
               chk(q.size() != 0, $sformatf("cfg%0d_extra_output", g), gdo, 0);
               if (q.size() != 0) begin
                  ge = q.pop_front();
                  chk(gdo == ge, $sformatf("cfg%0d_data", g), gdo, ge);
               end
               gcnt_m--;
            end
            if (gv && gready) begin
               q.push_back(gexp);
               gcnt_m++;
            end
         end
      end

      initial begin
         gv = 1'b0; gyen = 1'b0; gdata = '0; gmode = 2'd0; gexp = '0; gdone = 1'b0;
         wait (go);
         for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            gv   = ($urandom_range(0, 3) != 0);
            gyen = (n % 100 < 50) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) != 0);
            for (int b = 0; b < E*W; b++) gdata[b] = 1'($urandom_range(0, 1));
            gmode = 2'($urandom_range(0, 3));
            gexp  = ref_red(gdata, gmode);
         end
         @(posedge clk);
         #1;
         gv   = 1'b0;
         gyen = 1'b1;
         for (int n = 0; n < 40 && q.size() != 0; n++) begin
            @(posedge clk);
            #1;
         end
         chk(q.size() == 0, $sformatf("cfg%0d_drain", g), q.size(), 0);
         gdone = 1'b1;
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      vecs[0]  = '{2'd0, 12'h001, 4'hE};
      vecs[1]  = '{2'd0, 12'hCA9, 4'h0};
      vecs[2]  = '{2'd1, 12'hCA9, 4'hF};
      vecs[3]  = '{2'd2, 12'hCA9, 4'h7};
      vecs[4]  = '{2'd3, 12'hCA9, 4'hF};
      vecs[5]  = '{2'd0, 12'h000, 4'hF};
      vecs[6]  = '{2'd1, 12'h000, 4'h0};
      vecs[7]  = '{2'd2, 12'hFFF, 4'h0};
      vecs[8]  = '{2'd3, 12'hFFF, 4'hF};
      vecs[9]  = '{2'd0, 12'h356, 4'h8};
      vecs[10] = '{2'd2, 12'h356, 4'hF};
      vecs[11] = '{2'd3, 12'h356, 4'h0};

      rst = 1'b1; v_i = 1'b0; data_i = '0; mode_i = 2'd0; exp_in = '0;
      yumi_en = 1'b0; yumi_force = 1'b0; go = 1'b0;
      repeat (2) cyc();
      chk(v_o == 1'b0,     "reset_v_o",     v_o, 0);
      chk(data_o == 4'h0,  "reset_data_o",  data_o, 0);
      chk(count_o == 2'd0, "reset_count_o", count_o, 0);
      chk(ready_o == 1'b1, "reset_ready_o", ready_o, 1);
      @(negedge clk);
      rst = 1'b0;
      cyc();

      // Single item: NOR of {0,0,1}, latency two cycles.
      yumi_en = 1'b1;
      drive(2'd0, 12'h001, 4'hE);
      cyc();
      v_i = 1'b0;
      chk(v_o == 1'b0, "t1_v_o_early", v_o, 0);
      cyc();
      chk(v_o == 1'b1,    "t1_v_o",    v_o, 1);
      chk(data_o == 4'hE, "t1_data_o", data_o, 4'hE);
      cyc();

      // Back-to-back table vectors, one per cycle.
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].mode, vecs[i].data, vecs[i].expd);
         cyc();
      end
      v_i = 1'b0;
      drain(20, "table_drain");

      // Stall with a full pipe, then simultaneous consume and accept.
      yumi_en = 1'b0;
      drive(2'd1, 12'hCA9, 4'hF);
      cyc();
      drive(2'd0, 12'h356, 4'h8);
      cyc();
      drive(2'd2, 12'hFFF, 4'h0);
      chk(ready_o == 1'b0, "t3_ready_full", ready_o, 0);
      chk(count_o == 2'd2, "t3_count_full", count_o, 2);
      cyc();
      chk(ready_o == 1'b0, "t3_ready_hold", ready_o, 0);
      chk(count_o == 2'd2, "t3_count_hold", count_o, 2);
      chk(data_o == 4'hF,  "t3_head_hold",  data_o, 4'hF);
      yumi_en = 1'b1;
      #1;
      chk(ready_o == 1'b1, "t3_ready_yumi", ready_o, 1);
      cyc();
      chk(count_o == 2'd2, "t3_count_swap", count_o, 2);
      chk(data_o == 4'h8,  "t3_head_swap",  data_o, 4'h8);
      v_i = 1'b0;
      drain(20, "t3_drain");

      // Asynchronous reset with two items in flight.
      yumi_en = 1'b0;
      drive(2'd1, 12'h001, 4'h1);
      cyc();
      drive(2'd3, 12'h356, 4'h0);
      cyc();
      v_i = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk(v_o == 1'b0,     "t5_v_o",     v_o, 0);
      chk(count_o == 2'd0, "t5_count_o", count_o, 0);
      chk(ready_o == 1'b1, "t5_ready_o", ready_o, 1);
      chk(data_o == 4'h0,  "t5_data_o",  data_o, 0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      cyc();
      yumi_en = 1'b1;
      drive(2'd0, 12'h001, 4'hE);
      cyc();
      v_i = 1'b0;
      n = 1;
      while (!v_o && n < 20) begin
         cyc();
         n++;
      end
      chk(n == 2, "t5_latency", n, 2);
      drain(20, "t5_drain");

      // Illegal yumi on an empty pipe leaves state untouched.
      yumi_en = 1'b0;
      cyc();
      yumi_force = 1'b1;
      cyc();
      chk(count_o == 2'd0, "t6_count_o", count_o, 0);
      chk(v_o == 1'b0,     "t6_v_o",     v_o, 0);
      yumi_force = 1'b0;
      cyc();
      chk(count_o == 2'd0, "t6_count_after", count_o, 0);

      // Randomised traffic on all configurations.
      go = 1'b1;
      for (n = 0; n < 5000 && !(gen_cfg[0].gdone && gen_cfg[1].gdone &&
                                gen_cfg[2].gdone && gen_cfg[3].gdone); n++) begin
         @(posedge clk);
      end
      chk(gen_cfg[0].gdone && gen_cfg[1].gdone && gen_cfg[2].gdone && gen_cfg[3].gdone,
          "random_done", n, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
